mod_tick_counter: RTL and testbench

Parametrised modulo tick counter, the generalised successor of the fixed 0–99 minutes counter used in the stopwatch datapath. It counts qualified tick pulses modulo MODULUS, either up or down, and supports synchronous clear, parallel load, and hold. It keeps a registered packed-BCD copy of the count for the display path and emits registered carry/borrow pulses for cascading into the next stage (seconds → minutes → hours).

---
 rtl/mod_tick_counter_if.sv | 30 +++
 rtl/mod_tick_counter.sv | 133 +++++++++++++
 tb/tb_mod_tick_counter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mod_tick_counter_if.sv
// mod_tick_counter_if: control inputs and count/status outputs of one tick counter stage.
interface mod_tick_counter_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 2
);
    logic                clr;
    logic                en;
    logic                tick;
    logic                dir;
    logic                load;
    logic [WIDTH-1:0]    load_val;
    logic [WIDTH-1:0]    count;
    logic [4*DIGITS-1:0] bcd;
    logic                bcd_valid;
    logic                busy;
    logic                carry;
    logic                borrow;
    logic                load_err;
    logic                tick_lost;

    modport master (
        output clr, en, tick, dir, load, load_val,
        input  count, bcd, bcd_valid, busy, carry, borrow, load_err, tick_lost
    );

    modport slave (
        input  clr, en, tick, dir, load, load_val,
        output count, bcd, bcd_valid, busy, carry, borrow, load_err, tick_lost
    );
endinterface

// File: rtl/mod_tick_counter.sv
// mod_tick_counter: modulo-MODULUS up/down tick counter with a live BCD copy,
// double-dabble conversion on load, and registered carry/borrow pulses.
module mod_tick_counter #(
    parameter int MODULUS = 100,
    parameter int WIDTH   = 8,
    parameter int DIGITS  = 2
) (
    input logic               clk,
    input logic               rst_n,
    mod_tick_counter_if.slave tc
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);
    localparam logic [SW-1:0]    LAST    = SW'(WIDTH - 1);

    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    localparam logic [BW-1:0] BCD_MAX = to_bcd(MODULUS - 1);

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_count, r_dd_bin;
    logic [BW-1:0]    r_bcd, r_dd_bcd;
    logic [SW-1:0]    r_step;
    logic             r_carry, r_borrow, r_load_err, r_tick_lost;
    logic [BW-1:0]    w_dd_adj, w_dd_next, w_bcd_inc, w_bcd_dec;
    logic             w_ci, w_bi, w_load_ok, w_done, w_at_max, w_at_zero;

    assign w_load_ok = tc.load && ({1'b0, tc.load_val} < MOD_W);
    assign w_done    = (r_state == S_CONV) && (r_step == LAST);
    assign w_at_max  = r_count == CNT_MAX;
    assign w_at_zero = r_count == '0;

    // One double-dabble step: add 3 to digits >= 5, then shift in the next binary bit.
    always_comb begin
        w_dd_adj = r_dd_bcd;
        for (int i = 0; i < DIGITS; i++)
            if (w_dd_adj[4*i +: 4] >= 4'd5) w_dd_adj[4*i +: 4] = w_dd_adj[4*i +: 4] + 4'd3;
        w_dd_next = {w_dd_adj[BW-2:0], r_dd_bin[WIDTH-1]};
    end

    always_comb begin
        w_bcd_inc = r_bcd;
        w_bcd_dec = r_bcd;
        w_ci      = 1'b1;
        w_bi      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_ci) begin
                w_ci = w_bcd_inc[4*i +: 4] == 4'd9;
                w_bcd_inc[4*i +: 4] = w_ci ? 4'd0 : w_bcd_inc[4*i +: 4] + 4'd1;
            end
            if (w_bi) begin
                w_bi = w_bcd_dec[4*i +: 4] == 4'd0;
                w_bcd_dec[4*i +: 4] = w_bi ? 4'd9 : w_bcd_dec[4*i +: 4] - 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (tc.clr) w_next = S_IDLE;
        else if (w_load_ok) w_next = S_CONV;
        else if (w_done) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_bcd       <= '0;
            r_dd_bin    <= '0;
            r_dd_bcd    <= '0;
            r_step      <= '0;
            r_carry     <= 1'b0;
            r_borrow    <= 1'b0;
            r_load_err  <= 1'b0;
            r_tick_lost <= 1'b0;
        end else begin
            r_carry     <= 1'b0;
            r_borrow    <= 1'b0;
            r_load_err  <= 1'b0;
            r_tick_lost <= 1'b0;
            if (r_state == S_CONV) begin
                r_dd_bcd <= w_dd_next;
                r_dd_bin <= r_dd_bin << 1;
                r_step   <= r_step + 1'b1;
            end
            if (w_done) r_bcd <= w_dd_next;
            if (tc.clr) begin
                r_count <= '0;
                r_bcd   <= '0;
            end else if (tc.load) begin
                if (w_load_ok) begin
                    r_count  <= tc.load_val;
                    r_dd_bin <= tc.load_val;
                    r_dd_bcd <= '0;
                    r_step   <= '0;
                end else r_load_err <= 1'b1;
            end else if (tc.tick && tc.en) begin
                if (r_state == S_CONV) r_tick_lost <= 1'b1;
                else if (!tc.dir) begin
                    r_count <= w_at_max ? '0 : r_count + 1'b1;
                    r_bcd   <= w_at_max ? '0 : w_bcd_inc;
                    r_carry <= w_at_max;
                end else begin
                    r_count  <= w_at_zero ? CNT_MAX : r_count - 1'b1;
                    r_bcd    <= w_at_zero ? BCD_MAX : w_bcd_dec;
                    r_borrow <= w_at_zero;
                end
            end
        end
    end

    assign tc.count     = r_count;
    assign tc.bcd       = r_bcd;
    assign tc.busy      = r_state == S_CONV;
    assign tc.bcd_valid = r_state == S_IDLE;
    assign tc.carry     = r_carry;
    assign tc.borrow    = r_borrow;
    assign tc.load_err  = r_load_err;
    assign tc.tick_lost = r_tick_lost;
endmodule

// File: tb/tb_mod_tick_counter.sv
// tb_mod_tick_counter: drives a 0..99 and a 0..59 counter with shared stimulus and
// checks both against an arithmetic model every cycle, plus literal checkpoints.
module tb_mod_tick_counter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0, en = 1'b0, tick = 1'b0, dir = 1'b0, load = 1'b0;
    logic [7:0] lv = '0;
    int         total = 0, bad = 0;

    int MODV[2] = '{100, 60};
    int WV[2]   = '{8, 6};
    int m_cnt[2]  = '{0, 0};
    int m_left[2] = '{0, 0};
    int m_conv[2] = '{0, 0};
    int m_bcdv[2] = '{0, 0};
    bit m_c[2]  = '{0, 0};
    bit m_b[2]  = '{0, 0};
    bit m_le[2] = '{0, 0};
    bit m_tl[2] = '{0, 0};

    always #5 clk = ~clk;

    mod_tick_counter_if #(.WIDTH(8), .DIGITS(2)) ifa ();
    mod_tick_counter_if #(.WIDTH(6), .DIGITS(2)) ifb ();

    assign ifa.clr = clr;  assign ifa.en = en;  assign ifa.tick = tick;
    assign ifa.dir = dir;  assign ifa.load = load;  assign ifa.load_val = lv;
    assign ifb.clr = clr;  assign ifb.en = en;  assign ifb.tick = tick;
    assign ifb.dir = dir;  assign ifb.load = load;  assign ifb.load_val = lv[5:0];

    mod_tick_counter #(.MODULUS(100), .WIDTH(8), .DIGITS(2)) dut_a (.clk(clk), .rst_n(rst_n), .tc(ifa));
    mod_tick_counter #(.MODULUS(60), .WIDTH(6), .DIGITS(2)) dut_b (.clk(clk), .rst_n(rst_n), .tc(ifb));

    function automatic int to_bcd(input int v);
        return ((v / 10) % 10) * 16 + v % 10;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        int lvd;
        bit was_busy;
        lvd      = (d == 0) ? int'(lv) : int'(lv) % 64;
        was_busy = m_left[d] > 0;
        m_c[d] = 0; m_b[d] = 0; m_le[d] = 0; m_tl[d] = 0;
        if (!rst_n) begin
            m_cnt[d] = 0; m_left[d] = 0; m_bcdv[d] = 0;
            return;
        end
        if (was_busy) begin
            m_left[d]--;
            if (m_left[d] == 0) m_bcdv[d] = m_conv[d];
        end
        if (clr) begin
            m_cnt[d] = 0; m_bcdv[d] = 0; m_left[d] = 0;
        end else if (load) begin
            if (lvd < MODV[d]) begin
                m_cnt[d] = lvd; m_left[d] = WV[d]; m_conv[d] = lvd;
            end else m_le[d] = 1;
        end else if (tick && en) begin
            if (was_busy) m_tl[d] = 1;
            else begin
                if (!dir) begin
                    m_c[d]   = m_cnt[d] == MODV[d] - 1;
                    m_cnt[d] = (m_cnt[d] + 1) % MODV[d];
                end else begin
                    m_b[d]   = m_cnt[d] == 0;
                    m_cnt[d] = (m_cnt[d] + MODV[d] - 1) % MODV[d];
                end
                m_bcdv[d] = m_cnt[d];
            end
        end
    endtask

    task automatic cmp_dut(input int d, input logic [31:0] cnt, bcd, bv, bs, c, b, le, tl);
        string p;
        p = (d == 0) ? "m100" : "m60";
        check({p, " count"}, cnt, m_cnt[d]);
        check({p, " busy"}, bs, 32'(m_left[d] > 0));
        check({p, " bcd_valid"}, bv, 32'(m_left[d] == 0));
        if (m_left[d] == 0) check({p, " bcd"}, bcd, to_bcd(m_bcdv[d]));
        check({p, " carry"}, c, 32'(m_c[d]));
        check({p, " borrow"}, b, 32'(m_b[d]));
        check({p, " load_err"}, le, 32'(m_le[d]));
        check({p, " tick_lost"}, tl, 32'(m_tl[d]));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            cmp_dut(0, ifa.count, ifa.bcd, ifa.bcd_valid, ifa.busy, ifa.carry, ifa.borrow, ifa.load_err, ifa.tick_lost);
            cmp_dut(1, ifb.count, ifb.bcd, ifb.bcd_valid, ifb.busy, ifb.carry, ifb.borrow, ifb.load_err, ifb.tick_lost);
        end
    end

    task automatic cyc(input logic c, input logic l, input logic t, input logic dr, input logic [7:0] v);
        clr = c; load = l; tick = t; dir = dr; lv = v;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset count", ifa.count, 0);
        check("reset bcd", ifa.bcd, 0);
        check("reset bcd_valid", ifa.bcd_valid, 1);
        check("reset busy", ifa.busy, 0);
        check("reset pulses", {ifa.carry, ifa.borrow, ifa.load_err, ifa.tick_lost}, 0);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (99) cyc(0, 0, 1, 0, 0);
        check("up99 count", ifa.count, 99);
        check("up99 bcd", ifa.bcd, 'h99);
        check("up99 m60 count", ifb.count, 39);
        cyc(0, 0, 1, 0, 0);
        check("wrap count", ifa.count, 0);
        check("wrap bcd", ifa.bcd, 'h00);
        check("wrap carry", ifa.carry, 1);
        cyc(0, 0, 0, 0, 0);
        check("carry one cycle", ifa.carry, 0);
        cyc(0, 0, 1, 1, 0);
        check("down wrap count", ifa.count, 99);
        check("down wrap bcd", ifa.bcd, 'h99);
        check("down wrap borrow", ifa.borrow, 1);
        repeat (10) cyc(0, 0, 1, 1, 0);
        check("down10 count", ifa.count, 89);
        check("down10 bcd", ifa.bcd, 'h89);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        check("m60 down wrap count", ifb.count, 59);
        check("m60 down wrap bcd", ifb.bcd, 'h59);
        check("m60 borrow", ifb.borrow, 1);
        cyc(0, 0, 1, 0, 0);
        check("m60 up wrap count", ifb.count, 0);
        check("m60 carry", ifb.carry, 1);
        cyc(0, 1, 0, 0, 57);
        check("load count", ifa.count, 57);
        check("load busy", ifa.busy, 1);
        check("load bcd_valid", ifa.bcd_valid, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("busy tick_lost", ifa.tick_lost, 1);
        check("busy tick count", ifa.count, 57);
        repeat (4) cyc(0, 0, 0, 0, 0);
        check("busy last cycle", ifa.busy, 1);
        cyc(0, 0, 0, 0, 0);
        check("conv done busy", ifa.busy, 0);
        check("conv done valid", ifa.bcd_valid, 1);
        check("conv done bcd", ifa.bcd, 'h57);
        cyc(0, 1, 0, 0, 100);
        check("bad load err", ifa.load_err, 1);
        check("bad load count", ifa.count, 57);
        check("bad load bcd", ifa.bcd, 'h57);
        repeat (8) cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 42);
        check("clr prio count", ifa.count, 0);
        check("clr prio tick_lost", ifa.tick_lost, 0);
        check("clr prio busy", ifa.busy, 0);
        cyc(0, 1, 0, 0, 45);
        cyc(0, 0, 0, 0, 0);
        check("m60 conv busy", ifb.busy, 1);
        rst_n = 1'b0;
        #1;
        check("async rst m60 count", ifb.count, 0);
        check("async rst m60 busy", ifb.busy, 0);
        check("async rst m60 valid", ifb.bcd_valid, 1);
        check("async rst m60 bcd", ifb.bcd, 0);
        check("async rst m100 busy", ifa.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc(0, 0, 1, 0, 0);
        en = 1'b0;
        repeat (20) cyc(0, 0, 1, 0, 0);
        check("en0 hold count", ifa.count, 5);
        check("en0 no tick_lost", ifa.tick_lost, 0);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, logic'(i % 2), 0);
            check("dir toggle count", ifa.count, (i % 2 == 0) ? 6 : 5);
        end
        for (int i = 0; i < 3000; i++) begin
            en = $urandom_range(0, 7) != 0;
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 1)), 8'($urandom_range(0, 127)));
        end
        cyc(0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
